mem_copy_dma: RTL and testbench

Block-copy engine that acts as the initiator on the single-cycle, byte-addressable, 16-bit-word memory port (`data_out`/`data_in`/`addr`/`enable`/`wr`). Given a source address, destination address and word count, it copies words one at a time by alternating a read cycle and a write cycle. It never overlaps a read with a write. It sits beside the processor as a memory-port master; arbitration with the CPU is outside this block.

---
 rtl/mem_copy_dma_pkg.sv | 13 +
 rtl/mem_copy_dma.sv | 109 ++++++++++
 tb/tb_mem_copy_dma.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the block-copy DMA engine: state encodings and word size.
package mem_copy_dma_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2,
        DMA_DONE  = 2'd3
    } dma_state_e;

    localparam int WORD_BYTES = 2;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy engine: alternates one read and one write cycle per word on a
// single-cycle memory port, copying word_count words from src to dst.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int ADDR_STEP = WORD_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_enable,
    output logic        mem_wr
);

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    dma_state_e  state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] words_done_q, words_done_d;

    // NOTE: every datapath register is reset, not only the state, so that the
    // port shows all-zero outputs immediately after an aborted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DMA_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            buf_q        <= '0;
            words_done_q <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            buf_q        <= buf_d;
            words_done_q <= words_done_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path through the case
        // leaves a signal unassigned and infers a latch.
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        buf_d        = buf_q;
        words_done_d = words_done_q;

        unique case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    rem_d        = word_count;
                    words_done_d = '0;
                    state_d      = (word_count == 16'd0) ? DMA_DONE : DMA_READ;
                end
            end
            DMA_READ: begin
                buf_d   = mem_rdata;
                src_d   = src_q + STEP;
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                dst_d        = dst_q + STEP;
                rem_d        = rem_q - 16'd1;
                words_done_d = words_done_q + 16'd1;
                // rem_q == 1 means the decremented count reaches zero
                state_d      = (rem_q == 16'd1) ? DMA_DONE : DMA_READ;
            end
            DMA_DONE: state_d = DMA_IDLE;
            default:  state_d = DMA_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and data only
    always_comb begin
        mem_addr = '0;
        unique case (state_q)
            DMA_READ:  mem_addr = src_q;
            DMA_WRITE: mem_addr = dst_q;
            default:   mem_addr = '0;
        endcase
    end

    assign mem_enable = (state_q == DMA_READ) || (state_q == DMA_WRITE);
    assign mem_wr     = (state_q == DMA_WRITE);
    assign busy       = mem_enable;
    assign done       = (state_q == DMA_DONE);
    assign mem_wdata  = buf_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: table of copy transfers against a
// forward-copy memory model, plus hand-written reset-abort sequence.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, mem_enable, mem_wr;
    logic [15:0] words_done, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [0:32767];
    logic [15:0] exp_mem [0:32767];
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    int          en_cnt = 0;
    logic        prev_wr = 1'b0;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] n;
        int          done_cyc;
        int          inject;
    } vec_t;

    vec_t vecs[5];

    mem_copy_dma #(.ADDR_STEP(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_enable (mem_enable),
        .mem_wr     (mem_wr)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:1]];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_enable) en_cnt++;
            if (mem_enable && !mem_wr) rd_q.push_back(mem_addr);
            if (mem_wr) begin
                check("wr_needs_en", {31'd0, mem_enable}, 32'd1);
                check("no_back_to_back_wr", {31'd0, prev_wr}, 32'd0);
                wr_q.push_back(mem_addr);
            end
            prev_wr = mem_wr;
        end
    end

    task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] n);
        logic [15:0] s, d;
        s = src;
        d = dst;
        for (int i = 0; i < int'(n); i++) begin
            exp_mem[d[15:1]] = exp_mem[s[15:1]];
            s = s + 16'd2;
            d = d + 16'd2;
        end
    endtask

    task automatic run_copy(input vec_t v);
        int          done_cyc;
        int          done_hi;
        int          last;
        int          mism;
        logic [15:0] a;
        rd_q.delete();
        wr_q.delete();
        en_cnt   = 0;
        done_cyc = 0;
        done_hi  = 0;
        last     = 2 * int'(v.n) + 2;
        model_copy(v.src, v.dst, v.n);

        @(negedge clk);
        src_addr   = v.src;
        dst_addr   = v.dst;
        word_count = v.n;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            if (v.inject == cyc) begin
                start      = 1'b1;
                src_addr   = 16'h0700;
                dst_addr   = 16'h0800;
                word_count = 16'd1;
            end else if (v.inject != 0 && cyc == v.inject + 1) begin
                start = 1'b0;
            end
            if (done) begin
                done_hi++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    check("words_done_at_done", {16'd0, words_done}, {16'd0, v.n});
                end
            end
            if (cyc == last) check("idle_after_done", {30'd0, busy, done}, 32'd0);
        end
        start = 1'b0;

        check("done_cycle", done_cyc, v.done_cyc);
        check("done_pulse_width", done_hi, 1);
        check("enable_cycles", en_cnt, 2 * int'(v.n));
        check("read_count", rd_q.size(), int'(v.n));
        check("write_count", wr_q.size(), int'(v.n));
        for (int i = 0; i < rd_q.size() && i < int'(v.n); i++) begin
            a = v.src + 16'(2 * i);
            check("read_addr", {16'd0, rd_q[i]}, {16'd0, a});
        end
        for (int i = 0; i < wr_q.size() && i < int'(v.n); i++) begin
            a = v.dst + 16'(2 * i);
            check("write_addr", {16'd0, wr_q[i]}, {16'd0, a});
        end
        mism = 0;
        for (int w = 0; w < 32768; w++) if (mem[w] !== exp_mem[w]) mism++;
        check("mem_image", mism, 0);
    endtask

    initial begin
        for (int w = 0; w < 32768; w++) begin
            mem[w]     = 16'(w * 7 + 3);
            exp_mem[w] = 16'(w * 7 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            mem[16'h0080 + i]     = 16'hA001 + 16'(i);
            exp_mem[16'h0080 + i] = 16'hA001 + 16'(i);
        end
        mem[16'h7FFF] = 16'hBEEF;  exp_mem[16'h7FFF] = 16'hBEEF;
        mem[16'h0000] = 16'hCAFE;  exp_mem[16'h0000] = 16'hCAFE;
        mem[16'h0480] = 16'h5A5A;  exp_mem[16'h0480] = 16'h5A5A;

        //            src       dst       n      done inject
        vecs[0] = '{16'h0100, 16'h0200, 16'd4, 9, 0};
        vecs[1] = '{16'h0300, 16'h0310, 16'd0, 1, 0};
        vecs[2] = '{16'hFFFE, 16'h0400, 16'd2, 5, 0};
        vecs[3] = '{16'h0500, 16'h0600, 16'd3, 7, 3};
        vecs[4] = '{16'h0900, 16'h0902, 16'd3, 7, 0};

        #12;
        check("reset_busy",       {31'd0, busy},       32'd0);
        check("reset_done",       {31'd0, done},       32'd0);
        check("reset_mem_enable", {31'd0, mem_enable}, 32'd0);
        check("reset_mem_wr",     {31'd0, mem_wr},     32'd0);
        check("reset_words_done", {16'd0, words_done}, 32'd0);
        check("reset_mem_addr",   {16'd0, mem_addr},   32'd0);
        check("reset_mem_wdata",  {16'd0, mem_wdata},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) run_copy(vecs[k]);

        for (int i = 0; i < 4; i++)
            check("copy4_dst_word", {16'd0, mem[16'h0100 + i]}, {16'd0, 16'hA001 + 16'(i)});
        check("copy4_src_kept", {16'd0, mem[16'h0080]}, 32'h0000A001);
        check("wrap_dst0", {16'd0, mem[16'h0200]}, 32'h0000BEEF);
        check("wrap_dst1", {16'd0, mem[16'h0201]}, 32'h0000CAFE);
        for (int i = 1; i < 4; i++)
            check("overlap_replicate", {16'd0, mem[16'h0480 + i]}, 32'h00005A5A);

        // Reset asserted during the write of word 2 of a 5-word copy
        @(negedge clk);
        src_addr   = 16'h0B00;
        dst_addr   = 16'h0C00;
        word_count = 16'd5;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) @(negedge clk);
        check("abort_in_write", {31'd0, mem_wr}, 32'd1);
        check("abort_words_done_pre", {16'd0, words_done}, 32'd1);
        model_copy(16'h0B00, 16'h0C00, 16'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",       {31'd0, busy},       32'd0);
        check("abort_mem_enable", {31'd0, mem_enable}, 32'd0);
        check("abort_mem_wr",     {31'd0, mem_wr},     32'd0);
        check("abort_words_done", {16'd0, words_done}, 32'd0);
        check("abort_mem_addr",   {16'd0, mem_addr},   32'd0);
        check("abort_mem_wdata",  {16'd0, mem_wdata},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_copy('{16'h0B00, 16'h0C00, 16'd5, 11, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
